// File: rtl/dram_sc_rep_pkg.sv
// Shared defaults and the request record for the DRAM/scbuf repeater slice.
package dram_sc_rep_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int ECC_W_DEF     = 28;
  localparam int STAGES_DEF    = 2;
  localparam int REQ_DEPTH_DEF = 4;
  localparam int CNT_W_DEF     = 8;

  // One queued sctag->DRAM request: write flag, read id and line address.
  typedef struct packed {
    logic        wr;
    logic [2:0]  id;
    logic [39:5] addr;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/dram_sc_rep_fifo.sv
// Registered-output request FIFO: no fall-through, ready from count only.
module dram_sc_rep_fifo
  import dram_sc_rep_pkg::*;
#(
  parameter int WIDTH = REQ_W,
  parameter int DEPTH = REQ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_rdy,
  input  logic             pop_req,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Ready never looks at the pop, so a full FIFO refuses a push even when
  // the head leaves in the same cycle.
  assign push_rdy  = (count < FULL);
  assign head_vld  = (count != '0);
  assign push      = push_req & push_rdy;
  assign pop       = pop_req & head_vld;
  assign head_data = mem[rptr];

  // Storage is not reset; head fields are meaningless while head_vld is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_sc_rep_pipe.sv
// DRAM<->scbuf/sctag repeater: staged read-return path with ECC error
// counters, plus a request FIFO toward the DRAM controller.
module dram_sc_rep_pipe
  import dram_sc_rep_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ECC_W     = ECC_W_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int REQ_DEPTH = REQ_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              rclk,
  input  logic              arst_l,
  // read return path
  input  logic [DATA_W-1:0] dram_scbuf_data_r2,
  input  logic [ECC_W-1:0]  dram_scbuf_ecc_r2,
  input  logic              dram_scbuf_vld_r2,
  output logic [DATA_W-1:0] dram_scbuf_data_r2_buf,
  output logic [ECC_W-1:0]  dram_scbuf_ecc_r2_buf,
  output logic              dram_scbuf_vld_r2_buf,
  // ECC error flags
  input  logic              dram_sctag_secc_err_r2,
  input  logic              dram_sctag_mecc_err_r2,
  output logic              dram_sctag_secc_err_r2_buf,
  output logic              dram_sctag_mecc_err_r2_buf,
  // request path
  input  logic              sctag_dram_req_vld,
  input  logic              sctag_dram_req_wr,
  input  logic [2:0]        sctag_dram_rd_req_id,
  input  logic [39:5]       sctag_dram_addr,
  output logic              sctag_dram_req_rdy,
  output logic              sctag_dram_req_vld_buf,
  output logic              sctag_dram_req_wr_buf,
  output logic [2:0]        sctag_dram_rd_req_id_buf,
  output logic [39:5]       sctag_dram_addr_buf,
  input  logic              sctag_dram_req_rdy_buf,
  // error counters
  input  logic              err_cnt_clr,
  output logic [CNT_W-1:0]  secc_cnt,
  output logic [CNT_W-1:0]  mecc_cnt
);

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage registers, index 0 nearest the inputs.
  logic              vld_p  [STAGES];
  logic              secc_p [STAGES];
  logic              mecc_p [STAGES];
  logic [DATA_W-1:0] data_p [STAGES];
  logic [ECC_W-1:0]  ecc_p  [STAGES];

  // Return pipeline: flags move every cycle, data/ecc only follow a valid
  // beat so the output holds the last delivered word between beats.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s]  <= 1'b0;
        secc_p[s] <= 1'b0;
        mecc_p[s] <= 1'b0;
        data_p[s] <= '0;
        ecc_p[s]  <= '0;
      end
    end else begin
      vld_p[0]  <= dram_scbuf_vld_r2;
      secc_p[0] <= dram_sctag_secc_err_r2;
      mecc_p[0] <= dram_sctag_mecc_err_r2;
      if (dram_scbuf_vld_r2) begin
        data_p[0] <= dram_scbuf_data_r2;
        ecc_p[0]  <= dram_scbuf_ecc_r2;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1];
        secc_p[s] <= secc_p[s-1];
        mecc_p[s] <= mecc_p[s-1];
        if (vld_p[s-1]) begin
          data_p[s] <= data_p[s-1];
          ecc_p[s]  <= ecc_p[s-1];
        end
      end
    end
  end

  assign dram_scbuf_vld_r2_buf      = vld_p[STAGES-1];
  assign dram_scbuf_data_r2_buf     = data_p[STAGES-1];
  assign dram_scbuf_ecc_r2_buf      = ecc_p[STAGES-1];
  assign dram_sctag_secc_err_r2_buf = secc_p[STAGES-1];
  assign dram_sctag_mecc_err_r2_buf = mecc_p[STAGES-1];

  // Error counters count flags as seen on the buffered outputs, whether or
  // not a data beat accompanied them; clear wins over a same-cycle hit.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      secc_cnt <= '0;
      mecc_cnt <= '0;
    end else if (err_cnt_clr) begin
      secc_cnt <= '0;
      mecc_cnt <= '0;
    end else begin
      if (dram_sctag_secc_err_r2_buf) begin
        secc_cnt <= sat_inc(secc_cnt);
      end
      if (dram_sctag_mecc_err_r2_buf) begin
        mecc_cnt <= sat_inc(mecc_cnt);
      end
    end
  end

  req_t push_rec;
  req_t head_rec;

  assign push_rec.wr   = sctag_dram_req_wr;
  assign push_rec.id   = sctag_dram_rd_req_id;
  assign push_rec.addr = sctag_dram_addr;

  dram_sc_rep_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (rclk),
    .rst_n     (arst_l),
    .push_req  (sctag_dram_req_vld),
    .push_data (push_rec),
    .push_rdy  (sctag_dram_req_rdy),
    .pop_req   (sctag_dram_req_rdy_buf),
    .head_vld  (sctag_dram_req_vld_buf),
    .head_data (head_rec)
  );

  assign sctag_dram_req_wr_buf    = head_rec.wr;
  assign sctag_dram_rd_req_id_buf = head_rec.id;
  assign sctag_dram_addr_buf      = head_rec.addr;

endmodule

// File: doc/dram_sc_rep_pipe.md
DRAM_SC_REP_PIPE -- requirements
Module: dram_sc_rep_pipe

Interface
REQ-001 Parameter DATA_W, default 128, width of the DRAM-to-scbuf read data.
REQ-002 Parameter ECC_W, default 28, width of the read-data ECC.
REQ-003 Parameter STAGES, default 2, legal range 1..4: number of register stages on the return path.
REQ-004 Parameter REQ_DEPTH, default 4, power of 2 in the range 2..16: depth of the request FIFO.
REQ-005 Parameter CNT_W, default 8: width of the error counters.
REQ-006 Port rclk, in, 1: the single clock; all state changes on its rising edge.
REQ-007 Port arst_l, in, 1: reset, asynchronous and active-low.
REQ-008 Return-path inputs:
- dram_scbuf_data_r2, in, DATA_W: read data.
- dram_scbuf_ecc_r2, in, ECC_W: read-data ECC.
- dram_scbuf_vld_r2, in, 1: data qualifier.
REQ-009 Return-path outputs: dram_scbuf_data_r2_buf (DATA_W), dram_scbuf_ecc_r2_buf (ECC_W), dram_scbuf_vld_r2_buf (1).
REQ-010 Error inputs, each in, 1: dram_sctag_secc_err_r2, dram_sctag_mecc_err_r2.
REQ-011 Error outputs, each out, 1: dram_sctag_secc_err_r2_buf, dram_sctag_mecc_err_r2_buf.
REQ-012 Request inputs:
- sctag_dram_req_vld, in, 1.
- sctag_dram_req_wr, in, 1: 1 = write, 0 = read.
- sctag_dram_rd_req_id, in, 3.
- sctag_dram_addr, in, [39:5].
REQ-013 Port sctag_dram_req_rdy, out, 1: FIFO can accept a request.
REQ-014 Request outputs: sctag_dram_req_vld_buf, out, 1; sctag_dram_req_wr_buf, out, 1; sctag_dram_rd_req_id_buf, out, 3; sctag_dram_addr_buf, out, [39:5].
REQ-015 Port sctag_dram_req_rdy_buf, in, 1: the DRAM side accepts the head request.
REQ-016 Counter ports:
- err_cnt_clr, in, 1: synchronous clear.
- secc_cnt, out, CNT_W.
- mecc_cnt, out, CNT_W.

Function
REQ-017 Return path: vld, data, ecc and both error flags pass through STAGES register stages; latency is exactly STAGES cycles.
REQ-018 At each stage the vld and error-flag registers load every cycle.
REQ-019 Data and ecc registers load only when that stage's incoming vld = 1; otherwise they hold their value.
REQ-020 An error flag arriving with vld = 0 still propagates and is counted.
REQ-021 Request FIFO push = sctag_dram_req_vld & sctag_dram_req_rdy.
REQ-022 sctag_dram_req_rdy = (count < REQ_DEPTH); it is derived from registered count only and has no dependency on the pop.
REQ-023 Pop = sctag_dram_req_vld_buf & sctag_dram_req_rdy_buf.
REQ-024 sctag_dram_req_vld_buf = (count != 0); the head fields are driven from FIFO storage.
REQ-025 No fall-through: a push into an empty FIFO appears on the outputs the next cycle.
REQ-026 A simultaneous push and pop leaves count unchanged and preserves order.
REQ-027 When the FIFO is full, push is blocked even if a pop occurs in the same cycle.
REQ-028 Read and write pointers wrap modulo REQ_DEPTH; count is log2(REQ_DEPTH)+1 bits.
REQ-029 Head fields are don't-care while sctag_dram_req_vld_buf = 0.
REQ-030 secc_cnt increments by 1 when dram_sctag_secc_err_r2_buf = 1; mecc_cnt increments by 1 when dram_sctag_mecc_err_r2_buf = 1.
REQ-031 Both counters saturate at 2^CNT_W-1.
REQ-032 err_cnt_clr = 1 zeroes both counters next cycle and takes priority over a same-cycle increment.

Reset
REQ-033 While arst_l = 0, all of the following are 0 immediately, independent of rclk: stage registers, vld/err outputs, FIFO pointers and count, sctag_dram_req_vld_buf, and both counters.
REQ-034 sctag_dram_req_rdy = 1 from reset.
REQ-035 Reset asserted mid-transfer discards in-flight return data and queued requests; nothing is replayed.
REQ-036 Reset deassertion is synchronised externally to rclk.

Structure
REQ-037 Package dram_sc_rep_pkg holds the parameter defaults and the request record type {wr, id[2:0], addr[39:5]}.
REQ-038 The FIFO is sub-module dram_sc_rep_fifo, parametrised by width and depth.
REQ-039 The stage pipeline and counters are coded inline.

Verification
REQ-040 STAGES=3: vld=1, data=128'hA5..A5 at cycle 0, then vld=0 with data=0 at cycle 1 -> vld_buf=1 and data_buf=A5..A5 at cycle 3; data_buf still A5..A5 at cycle 4.
REQ-041 REQ_DEPTH=4 with rdy_buf=0: push ids 0..4 back-to-back -> rdy=0 after the 4th push, id 4 not accepted; set rdy_buf=1 -> ids 0,1,2,3 emerge in order over 4 cycles.
REQ-042 Count=2 with push and pop in the same cycle -> count stays 2 and the order is preserved; push into an empty FIFO -> vld_buf rises one cycle later.
REQ-043 CNT_W=8: 300 secc pulses -> secc_cnt=255; err_cnt_clr coinciding with a mecc pulse -> mecc_cnt=0.
REQ-044 Drop arst_l while the FIFO count is 3 and a return-path vld is in flight -> all outputs go 0 immediately, rdy=1, and no stale vld_buf appears after release.
